// File: rtl/reg_read_stage_if.sv
// Operand-read stage bus: decode request, execute slot, write-back port and flush.
// slave  = the reg_read_stage side, master = the surrounding pipeline side.
interface reg_read_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
);
    localparam int unsigned AW = $clog2(NREGS);

    // Decode side
    logic            id_valid;
    logic            id_ready;
    logic [AW-1:0]   id_rs1;
    logic [AW-1:0]   id_rs2;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic [AW-1:0]   id_rd;
    logic            id_rd_we;

    // Execute slot
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [AW-1:0]   ex_rd;
    logic            ex_rd_we;

    // Write-back port and pipeline kill
    logic            wb_we;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we,
        output id_ready,
        output ex_valid, ex_rs1_data, ex_rs2_data, ex_rd, ex_rd_we,
        input  ex_ready,
        input  wb_we, wb_rd, wb_data, flush
    );

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we,
        input  id_ready,
        input  ex_valid, ex_rs1_data, ex_rs2_data, ex_rd, ex_rd_we,
        output ex_ready,
        output wb_we, wb_rd, wb_data, flush
    );
endinterface

// File: rtl/reg_read_stage.sv
// Register file + operand-read stage with a per-register busy scoreboard and a
// one-entry registered output slot towards execute.
// Optional feature macro: REGFILE_BYPASS_EN -- forwards same-cycle write-back data
// into the slot so a source hazard resolves in the write-back cycle itself.
module reg_read_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic                    clk,
    input  logic                    rst,   // asynchronous, active low
    reg_read_stage_if.slave         bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;

    logic            ex_valid_q;
    logic [XLEN-1:0] ex_rs1_q, ex_rs2_q;
    logic [AW-1:0]   ex_rd_q;
    logic            ex_rd_we_q;

    logic            byp1, byp2;
    logic            haz1, haz2, waw;
    logic            ready, accept;
    logic            wb_write;
    logic [XLEN-1:0] op1, op2;

    assign wb_write = bus.wb_we && (bus.wb_rd != '0);

`ifdef REGFILE_BYPASS_EN
    assign byp1 = bus.wb_we && (bus.wb_rd == bus.id_rs1);
    assign byp2 = bus.wb_we && (bus.wb_rd == bus.id_rs2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // Hazard detection and handshake; a same-cycle write-back of rd clears WAW
    // in either build because the array write lands before the new set.
    always_comb begin
        haz1   = bus.id_rs1_used && (bus.id_rs1 != '0) && busy_q[bus.id_rs1] && !byp1;
        haz2   = bus.id_rs2_used && (bus.id_rs2 != '0) && busy_q[bus.id_rs2] && !byp2;
        waw    = bus.id_rd_we && (bus.id_rd != '0) && busy_q[bus.id_rd] &&
                 !(bus.wb_we && (bus.wb_rd == bus.id_rd));
        ready  = !bus.flush && !haz1 && !haz2 && !waw && (!ex_valid_q || bus.ex_ready);
        accept = bus.id_valid && ready;
    end

    // Operand selection: x0 is hardwired, bypass beats the array.
    always_comb begin
        op1 = regs_q[bus.id_rs1];
        op2 = regs_q[bus.id_rs2];
        if (byp1) op1 = bus.wb_data;
        if (byp2) op2 = bus.wb_data;
        if (bus.id_rs1 == '0) op1 = '0;
        if (bus.id_rs2 == '0) op2 = '0;
    end

    // Scoreboard next state: clears first, so an accept's set wins over them.
    always_comb begin
        busy_d = busy_q;
        if (bus.flush && ex_valid_q && ex_rd_we_q && (ex_rd_q != '0)) begin
            busy_d[ex_rd_q] = 1'b0;
        end
        if (wb_write) begin
            busy_d[bus.wb_rd] = 1'b0;
        end
        if (accept && bus.id_rd_we && (bus.id_rd != '0)) begin
            busy_d[bus.id_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Architectural register array; x0 is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_write) begin
            regs_q[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Output slot: flush kills, accept loads, consume empties, otherwise frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q <= 1'b0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
            ex_rd_we_q <= 1'b0;
        end else if (bus.flush) begin
            ex_valid_q <= 1'b0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            ex_rs1_q   <= op1;
            ex_rs2_q   <= op2;
            ex_rd_q    <= bus.id_rd;
            ex_rd_we_q <= bus.id_rd_we;
        end else if (bus.ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign bus.id_ready    = ready;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_rs1_data = ex_rs1_q;
    assign bus.ex_rs2_data = ex_rs2_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_rd_we    = ex_rd_we_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: directed scenarios followed by random traffic, all
// checked against a behavioural model of the register file, scoreboard and slot.
module tb_reg_read_stage;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;

    reg_read_stage_if #(.XLEN(32), .NREGS(32)) bus ();

    reg_read_stage #(.XLEN(32), .NREGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit last_acc;

    // Reference state
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_valid;
    logic [31:0] m_rs1, m_rs2;
    logic [4:0]  m_rd;
    bit          m_rd_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_valid = 1'b0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_rd_we = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] s);
        if (s == 0) return 32'h0;
        if (BYP && bus.wb_we && bus.wb_rd == s) return bus.wb_data;
        return m_regs[s];
    endfunction

    function automatic bit src_stall(input bit used, input logic [4:0] s);
        return used && s != 0 && m_busy[s] && !(BYP && bus.wb_we && bus.wb_rd == s);
    endfunction

    task automatic drive_id(input bit v, input logic [4:0] rs1, input bit u1,
                            input logic [4:0] rs2, input bit u2,
                            input logic [4:0] rd, input bit rdwe);
        bus.id_valid = v; bus.id_rs1 = rs1; bus.id_rs1_used = u1;
        bus.id_rs2 = rs2; bus.id_rs2_used = u2; bus.id_rd = rd; bus.id_rd_we = rdwe;
    endtask

    task automatic drive_wb(input bit we, input logic [4:0] rd, input logic [31:0] d);
        bus.wb_we = we; bus.wb_rd = rd; bus.wb_data = d;
    endtask

    // One clock: check id_ready mid-cycle, advance the model, check the slot after the edge.
    task automatic cycle();
        bit          stall, exp_rdy, acc;
        logic [31:0] n1, n2;
        @(negedge clk);
        stall = src_stall(bus.id_rs1_used, bus.id_rs1) ||
                src_stall(bus.id_rs2_used, bus.id_rs2) ||
                (bus.id_rd_we && bus.id_rd != 0 && m_busy[bus.id_rd] &&
                 !(bus.wb_we && bus.wb_rd == bus.id_rd));
        exp_rdy = !bus.flush && !stall && (!m_valid || bus.ex_ready);
        chk("id_ready", 32'(bus.id_ready), 32'(exp_rdy));
        last_acc = bus.id_valid && bus.id_ready;
        acc = bus.id_valid && exp_rdy;
        n1 = model_read(bus.id_rs1);
        n2 = model_read(bus.id_rs2);
        if (bus.flush && m_valid && m_rd_we && m_rd != 0) m_busy[m_rd] = 1'b0;
        if (bus.wb_we && bus.wb_rd != 0) begin
            m_regs[bus.wb_rd] = bus.wb_data;
            m_busy[bus.wb_rd] = 1'b0;
        end
        if (acc) begin
            m_valid = 1'b1; m_rs1 = n1; m_rs2 = n2; m_rd = bus.id_rd; m_rd_we = bus.id_rd_we;
            if (bus.id_rd_we && bus.id_rd != 0) m_busy[bus.id_rd] = 1'b1;
        end else if (bus.flush || bus.ex_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
        chk("ex_rs1_data", bus.ex_rs1_data, m_rs1);
        chk("ex_rs2_data", bus.ex_rs2_data, m_rs2);
        chk("ex_rd", 32'(bus.ex_rd), 32'(m_rd));
        chk("ex_rd_we", 32'(bus.ex_rd_we), 32'(m_rd_we));
    endtask

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    task automatic rand_inputs();
        logic [4:0] wr;
        int         start;
        drive_id($urandom_range(0, 3) != 0, pick_reg(), 1'($urandom_range(0, 1)),
                 pick_reg(), 1'($urandom_range(0, 1)), pick_reg(), 1'($urandom_range(0, 1)));
        bus.ex_ready = ($urandom_range(0, 3) != 0);
        bus.flush    = ($urandom_range(0, 15) == 0);
        wr = pick_reg();
        start = $urandom_range(0, 31);
        if ($urandom_range(0, 3) != 0) begin
            for (int i = 0; i < 32; i++) begin
                if (m_busy[(start + i) % 32]) begin
                    wr = 5'((start + i) % 32);
                    break;
                end
            end
        end
        drive_wb($urandom_range(0, 1) == 1, wr, $urandom);
    endtask

    initial begin
        int k;
        int exp_k;

        rst = 1'b0;
        drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        drive_wb(1'b0, 5'd0, 32'h0);
        bus.ex_ready = 1'b1;
        bus.flush = 1'b0;
        model_reset();

        // Reset state
        #12;
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'h0);
        chk("rst_ex_rs1", bus.ex_rs1_data, 32'h0);
        chk("rst_ex_rs2", bus.ex_rs2_data, 32'h0);
        chk("rst_ex_rd", 32'(bus.ex_rd), 32'h0);
        chk("rst_ex_rd_we", 32'(bus.ex_rd_we), 32'h0);
        chk("rst_id_ready", 32'(bus.id_ready), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Write x5 then read it alongside x0
        drive_wb(1'b1, 5'd5, 32'hDEADBEEF);
        cycle();
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
        cycle();
        chk("x5_read", bus.ex_rs1_data, 32'hDEADBEEF);
        chk("x0_read", bus.ex_rs2_data, 32'h0);

        // RAW on x3: stall until write-back
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        cycle();
        drive_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        exp_k = BYP ? 2 : 3;
        for (k = 0; k < 6; k++) begin
            drive_wb(k == 2, 5'd3, 32'h1234);
            cycle();
            if (last_acc) break;
        end
        chk("raw_accept_cycle", 32'(k), 32'(exp_k));
        chk("raw_data", bus.ex_rs1_data, 32'h1234);
        drive_wb(1'b0, 5'd0, 32'h0);

        // x0 writes are dropped and x0 never stalls
        drive_wb(1'b1, 5'd0, 32'hFFFFFFFF);
        drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle();
        chk("x0_after_write", bus.ex_rs1_data, 32'h0);
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        cycle();
        drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        cycle();
        chk("x0_no_stall", 32'(last_acc), 32'h1);

        // Backpressure freezes the slot
        drive_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle();
        bus.ex_ready = 1'b0;
        drive_id(1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_stall", 32'(last_acc), 32'h0);
            chk("bp_frozen", bus.ex_rs1_data, 32'hDEADBEEF);
        end
        bus.ex_ready = 1'b1;
        cycle();
        chk("bp_release", 32'(last_acc), 32'h1);
        chk("bp_new_rs2", bus.ex_rs2_data, 32'hDEADBEEF);

        // Flush clears the slot and its busy bit
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        cycle();
        bus.ex_ready = 1'b0;
        bus.flush = 1'b1;
        cycle();
        chk("flush_no_accept", 32'(last_acc), 32'h0);
        chk("flush_valid", 32'(bus.ex_valid), 32'h0);
        bus.flush = 1'b0;
        bus.ex_ready = 1'b1;
        cycle();
        chk("flush_busy_clear", 32'(last_acc), 32'h1);

        // WAW on x9
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        cycle();
        chk("waw_first", 32'(last_acc), 32'h1);
        cycle();
        chk("waw_stall", 32'(last_acc), 32'h0);
        drive_wb(1'b1, 5'd9, 32'h99);
        cycle();
        chk("waw_release", 32'(last_acc), 32'h1);
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle();
        chk("waw_still_busy", 32'(last_acc), 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle();
        end

        // Mid-operation reset
        bus.flush = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_valid", 32'(bus.ex_valid), 32'h0);
        chk("mid_rst_rd_we", 32'(bus.ex_rd_we), 32'h0);
        chk("mid_rst_rs1", bus.ex_rs1_data, 32'h0);
        chk("mid_rst_ready", 32'(bus.id_ready), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 200; i++) begin
            rand_inputs();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
